set_increment_sequencer: RTL and testbench

//   Turns the set-mode increment button into one-cycle increment pulses for the

---
 rtl/set_increment_sequencer.sv | 153 +++++++++++++++
 tb/tb_set_increment_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_increment_sequencer.sv
// Set-mode increment sequencer: turns a held increment button into one-cycle
// minute/hour increment pulses with tick-paced delay, slow and fast auto-repeat.
module set_increment_sequencer #(
    parameter int unsigned DELAY_TICKS = 500,
    parameter int unsigned SLOW_TICKS  = 200,
    parameter int unsigned FAST_TICKS  = 50,
    parameter int unsigned FAST_AFTER  = 8,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned RPT_W       = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tick,
    input  logic       i_Enable_Increment,
    input  logic [1:0] i_Select,
    input  logic       i_Button,
    output logic       o_Inc_Min,
    output logic       o_Inc_Hour,
    output logic       o_Repeat_Active,
    output logic       o_Fast
);

    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SLOW  = 2'd2,
        FAST  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [1:0]       sel_q, sel_d;
    logic             prev_q;
    logic             inc_min_q, inc_min_d;
    logic             inc_hour_q, inc_hour_d;
    logic             rpt_active_q, rpt_active_d;
    logic             fast_q, fast_d;

    logic             valid;
    logic             press;
    logic             abort;
    logic             terminal;
    logic             pulse;
    logic [RPT_W-1:0] rpt_inc;

    assign valid    = i_Enable_Increment && ((i_Select == SEL_MIN) || (i_Select == SEL_HOUR));
    assign press    = i_Button && !prev_q;
    // A held press belongs to the field it was made in; any change cancels it.
    assign abort    = !i_Button || !valid || (i_Select != sel_q);
    assign terminal = i_Tick && (cnt_q == CNT_W'(1));
    assign rpt_inc  = rpt_q + RPT_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rpt_q        <= '0;
            sel_q        <= '0;
            prev_q       <= 1'b1;
            inc_min_q    <= 1'b0;
            inc_hour_q   <= 1'b0;
            rpt_active_q <= 1'b0;
            fast_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rpt_q        <= rpt_d;
            sel_q        <= sel_d;
            prev_q       <= i_Button;
            inc_min_q    <= inc_min_d;
            inc_hour_q   <= inc_hour_d;
            rpt_active_q <= rpt_active_d;
            fast_q       <= fast_d;
        end
    end

    // Next-state, counter reloads and pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        sel_d   = sel_q;
        pulse   = 1'b0;

        case (state_q)
            IDLE: begin
                if (press && valid) begin
                    pulse   = 1'b1;
                    cnt_d   = CNT_W'(DELAY_TICKS);
                    rpt_d   = '0;
                    sel_d   = i_Select;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    pulse   = 1'b1;
                    cnt_d   = CNT_W'(SLOW_TICKS);
                    state_d = SLOW;
                end else if (i_Tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SLOW: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    pulse = 1'b1;
                    rpt_d = rpt_inc;
                    if (rpt_inc == RPT_W'(FAST_AFTER)) begin
                        cnt_d   = CNT_W'(FAST_TICKS);
                        state_d = FAST;
                    end else begin
                        cnt_d = CNT_W'(SLOW_TICKS);
                    end
                end else if (i_Tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FAST: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    pulse = 1'b1;
                    cnt_d = CNT_W'(FAST_TICKS);
                end else if (i_Tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inc_min_d    = pulse && (i_Select == SEL_MIN);
        inc_hour_d   = pulse && (i_Select == SEL_HOUR);
        rpt_active_d = (state_d == SLOW) || (state_d == FAST);
        fast_d       = (state_d == FAST);
    end

    assign o_Inc_Min       = inc_min_q;
    assign o_Inc_Hour      = inc_hour_q;
    assign o_Repeat_Active = rpt_active_q;
    assign o_Fast          = fast_q;

endmodule

// File: tb/tb_set_increment_sequencer.sv
// Testbench for set_increment_sequencer: directed vector table, hand-written
// corner sequences and random stimulus against a pulse-count reference model.
module tb_set_increment_sequencer;

    localparam int unsigned DELAY = 4;
    localparam int unsigned SLOW  = 2;
    localparam int unsigned FAST  = 1;
    localparam int unsigned FA    = 3;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       en;
    logic [1:0] sel;
    logic       btn;
    logic       o_min, o_hour, o_ra, o_fast;

    set_increment_sequencer #(
        .DELAY_TICKS(DELAY), .SLOW_TICKS(SLOW), .FAST_TICKS(FAST),
        .FAST_AFTER(FA), .CNT_W(10), .RPT_W(4)
    ) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tick(tick),
        .i_Enable_Increment(en), .i_Select(sel), .i_Button(btn),
        .o_Inc_Min(o_min), .o_Inc_Hour(o_hour),
        .o_Repeat_Active(o_ra), .o_Fast(o_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: an active hold, the ticks left until the next pulse and
    // how many repeat pulses have been issued since the press.
    bit         m_active;
    logic [1:0] m_sel;
    int         m_left;
    int         m_k;
    bit         m_prev;
    bit         m_min, m_hour, m_ra, m_fast;

    // Pulse spacing measured on the DUT outputs, in ticks.
    int tk_cnt;
    int gaps[$];

    typedef struct {
        logic       t;
        logic       e;
        logic [1:0] s;
        logic       b;
        logic       x_min;
        logic       x_hour;
        logic       x_ra;
        logic       x_fast;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d actual=timeout required=condition reached", name, cyc);
    endtask

    task automatic model_reset();
        m_active = 0; m_sel = 2'b00; m_left = 0; m_k = 0; m_prev = 1;
        m_min = 0; m_hour = 0; m_ra = 0; m_fast = 0;
    endtask

    task automatic do_pulse(input logic [1:0] s);
        m_min  = (s == 2'b01);
        m_hour = (s == 2'b10);
    endtask

    task automatic model_edge(input logic t, input logic e, input logic [1:0] s, input logic b);
        bit v;
        v = e && (s == 2'b01 || s == 2'b10);
        m_min = 0; m_hour = 0;
        if (m_active) begin
            if (!b || !v || s != m_sel) begin
                m_active = 0;
            end else if (t) begin
                m_left--;
                if (m_left == 0) begin
                    do_pulse(s);
                    m_k++;
                    m_left = (m_k <= int'(FA)) ? int'(SLOW) : int'(FAST);
                end
            end
        end else if (b && !m_prev && v) begin
            do_pulse(s);
            m_active = 1; m_sel = s; m_k = 0; m_left = int'(DELAY);
        end
        m_prev = b;
        m_ra   = m_active && (m_k >= 1);
        m_fast = m_active && (m_k > int'(FA));
    endtask

    task automatic step(input logic t, input logic e, input logic [1:0] s, input logic b);
        tick = t; en = e; sel = s; btn = b;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(t, e, s, b);
        #1;
        cyc++;
        check("inc_min", o_min, m_min);
        check("inc_hour", o_hour, m_hour);
        check("repeat_active", o_ra, m_ra);
        check("fast", o_fast, m_fast);
        if (t && rst_n) tk_cnt++;
        if (o_min === 1'b1 || o_hour === 1'b1) begin
            gaps.push_back(tk_cnt);
            tk_cnt = 0;
        end
    endtask

    // Step with the free-running tick (one cycle in four).
    task automatic astep(input logic e, input logic [1:0] s, input logic b);
        step((cyc % 4) == 0, e, s, b);
    endtask

    initial begin
        int exp_gaps[8];
        int pcount;
        bit found;

        exp_gaps = '{4, 2, 2, 2, 1, 1, 1, 1};

        //             t  e  s      b  min hr ra fast
        vecs[0]  = '{0, 1, 2'b01, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 2'b01, 1, 1, 0, 0, 0};
        vecs[2]  = '{0, 1, 2'b01, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 2'b01, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 2'b01, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 2'b00, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 2'b00, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 2'b11, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 2'b11, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 2'b10, 1, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 2'b10, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 2'b10, 1, 0, 1, 0, 0};
        vecs[12] = '{1, 1, 2'b10, 1, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 2'b10, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 1, 2'b10, 0, 0, 0, 0, 0};

        tk_cnt = 0;
        model_reset();
        rst_n = 1'b0; tick = 0; en = 0; sel = 2'b00; btn = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_inc_min", o_min, 1'b0);
        check("rst_inc_hour", o_hour, 1'b0);
        check("rst_repeat_active", o_ra, 1'b0);
        check("rst_fast", o_fast, 1'b0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].t, vecs[i].e, vecs[i].s, vecs[i].b);
            check($sformatf("vec%0d_min", i), o_min, vecs[i].x_min);
            check($sformatf("vec%0d_hour", i), o_hour, vecs[i].x_hour);
            check($sformatf("vec%0d_ra", i), o_ra, vecs[i].x_ra);
            check($sformatf("vec%0d_fast", i), o_fast, vecs[i].x_fast);
        end

        // Long hold on hours: delay, three slow repeats, then fast.
        astep(1, 2'b10, 0);
        gaps.delete();
        tk_cnt = 0;
        repeat (64) astep(1, 2'b10, 1);
        astep(1, 2'b10, 0);
        checks++;
        if (gaps.size() < 9) begin
            errors++;
            $display("FAIL hold_pulse_count actual=%0d required>=9", gaps.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (gaps[i+1] != exp_gaps[i]) begin
                    errors++;
                    $display("FAIL hold_gap%0d actual=%0d required=%0d", i, gaps[i+1], exp_gaps[i]);
                end
            end
        end

        // Mode change: enable drops in SLOW, then returns with the button held.
        astep(1, 2'b10, 0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            astep(1, 2'b10, 1);
            if (m_active && m_k >= 2) begin found = 1; break; end
        end
        if (!found) fail_now("reach_slow");
        pcount = 0;
        repeat (8) begin astep(0, 2'b10, 1); pcount += int'(o_hour) + int'(o_min); end
        repeat (24) begin astep(1, 2'b10, 1); pcount += int'(o_hour) + int'(o_min); end
        checks++;
        if (pcount != 0) begin
            errors++;
            $display("FAIL mode_change_pulses actual=%0d required=0", pcount);
        end
        astep(1, 2'b10, 0);
        astep(1, 2'b10, 1);
        check("repress_hour", o_hour, 1'b1);

        // Select change in FAST with the button held.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            astep(1, 2'b10, 1);
            if (m_active && m_k > int'(FA)) begin found = 1; break; end
        end
        if (!found) fail_now("reach_fast");
        check("in_fast", o_fast, 1'b1);
        pcount = 0;
        repeat (10) begin astep(1, 2'b01, 1); pcount += int'(o_min); end
        checks++;
        if (pcount != 0) begin
            errors++;
            $display("FAIL select_change_min_pulses actual=%0d required=0", pcount);
        end
        check("select_change_idle", o_ra, 1'b0);

        // Release coincident with a terminal tick.
        astep(1, 2'b10, 0);
        astep(1, 2'b10, 1);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_active && m_left == 1 && m_k >= 1 && m_k <= int'(FA) && (cyc % 4) == 0) begin
                found = 1; break;
            end
            astep(1, 2'b10, 1);
        end
        if (!found) fail_now("reach_collision");
        astep(1, 2'b10, 0);
        check("collision_no_pulse", o_hour, 1'b0);

        // Button held through reset release.
        astep(1, 2'b01, 1);
        rst_n = 1'b0;
        repeat (3) astep(1, 2'b01, 1);
        rst_n = 1'b1;
        pcount = 0;
        repeat (12) begin astep(1, 2'b01, 1); pcount += int'(o_min); end
        checks++;
        if (pcount != 0) begin
            errors++;
            $display("FAIL held_through_reset_pulses actual=%0d required=0", pcount);
        end

        // Reset asserted in FAST clears outputs immediately.
        astep(1, 2'b01, 0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            astep(1, 2'b01, 1);
            if (m_active && m_k > int'(FA) && o_min === 1'b1) begin found = 1; break; end
        end
        if (!found) fail_now("reach_fast_pulse");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_min", o_min, 1'b0);
        check("async_rst_ra", o_ra, 1'b0);
        check("async_rst_fast", o_fast, 1'b0);
        repeat (2) astep(1, 2'b01, 0);
        rst_n = 1'b1;
        repeat (3) astep(1, 2'b01, 0);
        check("after_rst_idle", o_ra, 1'b0);

        // Random stimulus against the reference model.
        en = 1; sel = 2'b10; btn = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       e;
            logic [1:0] s;
            logic       b;
            e = en; s = sel; b = btn;
            if ($urandom_range(0, 59) == 0) e = ~e;
            if (!e && $urandom_range(0, 3) == 0) e = 1;
            if ($urandom_range(0, 49) == 0)
                s = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
            if ($urandom_range(0, 24) == 0) b = ~b;
            astep(e, s, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
